stack_unit: RTL and testbench
=============================

# stack_unit

Parametrised LIFO operand stack for the stack-architecture datapath. It owns its own stack pointer and exposes the top two entries (TOS, NOS) combinationally so the ALU can read both operands without a pop cycle. It executes one stack operation per clock: push, pop, replace, dup, swap, binary-op writeback or clear. Illegal operations are dropped and recorded in sticky overflow and underflow flags.

## Interface
- WIDTH, 8, data width in bits (≥1)
- DEPTH, 4, number of entries (≥2). Count width CW = $clog2(DEPTH+1), derived, not a parameter.

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- op  in  3  operation code, sampled every rising edge
- data_in  in  WIDTH  write data for PUSH, REPLACE and BINOP
- err_clr  in  1  clears the sticky overflow and underflow flags
- tos  out  WIDTH  top of stack, mem[count-1]; 0 when count=0
- nos  out  WIDTH  next on stack, mem[count-2]; 0 when count<2
- count  out  CW  number of valid entries, 0..DEPTH
- empty  out  1  count==0
- full  out  1  count==DEPTH
- overflow  out  1  sticky: an op needed a free slot and none was available
- underflow  out  1  sticky: an op needed more entries than were valid

## Operation
- Storage: DEPTH×WIDTH register array plus the count register. Entry 0 is the bottom of the stack.
- Opcodes (required count in brackets; Δ is the change in count):
  - 000 NOP: no change.
  - 001 PUSH [count<DEPTH]: mem[count] ← data_in. Δ +1.
  - 010 POP [count≥1]: Δ −1. The data is not cleared.
  - 011 REPLACE [count≥1]: mem[count-1] ← data_in. Δ 0.
  - 100 DUP [1≤count<DEPTH]: mem[count] ← mem[count-1]. Δ +1.
  - 101 SWAP [count≥2]: exchange mem[count-1] and mem[count-2]. Δ 0.
  - 110 BINOP [count≥2]: mem[count-2] ← data_in. Δ −1.
    - Consumes TOS and NOS and pushes the result.
    - data_in is normally an ALU function of the current tos/nos.
  - 111 CLEAR: count ← 0. Never an error.
- Illegal op (precondition false): state is fully unchanged (array and count).
  - PUSH when full sets overflow.
  - DUP when full sets overflow.
  - DUP when empty sets underflow. Empty takes precedence: with DEPTH≥2 the two cannot coincide.
  - POP or REPLACE when count=0 sets underflow.
  - SWAP or BINOP when count<2 sets underflow.
- Flags:
  - overflow and underflow stay set until err_clr or rst.
  - If err_clr and a new error occur in the same cycle, the set wins.
  - err_clr has no effect on stack state.
- tos, nos, empty, full and count are combinational from the registered state. No read latency.
- Count arithmetic is unsigned CW-bit. It never wraps: the legality checks guarantee 0 ≤ count ≤ DEPTH.

## Timing
- Single clock domain. Every op completes in exactly one cycle. There is no handshake or stall; a new op is accepted every cycle.
- The new state is visible on tos, nos and count immediately after the rising edge where the op was sampled.
- BINOP data_in may be combinationally derived from tos/nos in the same cycle. The stack registers break the loop.
- Reset, with rst high at a rising edge:
  - count=0, overflow=0, underflow=0.
  - Therefore tos=0, nos=0, empty=1, full=0.
  - Array contents are don't-care and are not cleared.
- rst has priority over any op and over err_clr in the same cycle. An op presented during reset is discarded.
- rst asserted mid-sequence takes effect at that edge. The op in the following cycle sees count=0.

## Test plan
- Reset, then PUSH 0x11, 0x22, 0x33 → count=3, tos=0x33, nos=0x22. Then POP → tos=0x22, nos=0x11, count=2.
- DEPTH=4: PUSH 4 values, then PUSH 0xAA → full=1, count=4, tos unchanged, overflow=1. DUP → overflow stays 1, state unchanged. err_clr → overflow=0.
- From empty: POP, then SWAP → underflow=1, count=0, tos=0. PUSH 0x05, then BINOP → underflow stays 1, count=1, tos=0x05.
- Stack [0x03, 0x04] (TOS 0x04), data_in=tos+nos → BINOP → count=1, tos=0x07. Then DUP → count=2, tos=nos=0x07. Then SWAP and REPLACE 0x09 → tos=0x09, nos=0x07.
- err_clr in the same cycle as PUSH-when-full → overflow=1 afterwards. err_clr with no error → 0.
- With count=3, assert rst together with PUSH → count=0, empty=1, flags 0. CLEAR from full → count=0, no flag set.

Source files
------------

// File: rtl/stack_unit.sv
// LIFO operand stack with combinational TOS/NOS taps and one operation per clock.
// Illegal operations leave all state untouched and raise sticky overflow/underflow flags.
module stack_unit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data_in,
  input  logic             err_clr,
  output logic [WIDTH-1:0] tos,
  output logic [WIDTH-1:0] nos,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    OP_NOP     = 3'b000,
    OP_PUSH    = 3'b001,
    OP_POP     = 3'b010,
    OP_REPLACE = 3'b011,
    OP_DUP     = 3'b100,
    OP_SWAP    = 3'b101,
    OP_BINOP   = 3'b110,
    OP_CLEAR   = 3'b111
  } op_e;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic [CW-1:0] cnt_m1, cnt_m2;
  logic [AW-1:0] idx_free, idx_top, idx_next;
  logic          is_empty, is_full, has_two;
  op_e           op_e_w;

  assign op_e_w   = op_e'(op);
  assign cnt_m1   = count_q - CW'(1);
  assign cnt_m2   = count_q - CW'(2);
  assign idx_free = count_q[AW-1:0];
  assign idx_top  = cnt_m1[AW-1:0];
  assign idx_next = cnt_m2[AW-1:0];
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));
  assign has_two  = (count_q >= CW'(2));

  assign tos       = is_empty ? '0 : mem_q[idx_top];
  assign nos       = has_two ? mem_q[idx_next] : '0;
  assign count     = count_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = ovf_q;
  assign underflow = udf_q;

  // NOTE: every always_comb output is given its hold value first, so no path
  // through the case statement can leave a variable unassigned and infer a latch.
  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    ovf_d   = err_clr ? 1'b0 : ovf_q;
    udf_d   = err_clr ? 1'b0 : udf_q;

    unique case (op_e_w)
      OP_NOP: ;
      OP_PUSH: begin
        if (is_full) begin
          ovf_d = 1'b1;
        end else begin
          mem_d[idx_free] = data_in;
          count_d         = count_q + CW'(1);
        end
      end
      OP_POP: begin
        if (is_empty) udf_d = 1'b1;
        else          count_d = cnt_m1;
      end
      OP_REPLACE: begin
        if (is_empty) udf_d = 1'b1;
        else          mem_d[idx_top] = data_in;
      end
      OP_DUP: begin
        // Empty is checked first; with DEPTH >= 2 it cannot coincide with full.
        if (is_empty) begin
          udf_d = 1'b1;
        end else if (is_full) begin
          ovf_d = 1'b1;
        end else begin
          mem_d[idx_free] = mem_q[idx_top];
          count_d         = count_q + CW'(1);
        end
      end
      OP_SWAP: begin
        if (!has_two) begin
          udf_d = 1'b1;
        end else begin
          mem_d[idx_top]  = mem_q[idx_next];
          mem_d[idx_next] = mem_q[idx_top];
        end
      end
      OP_BINOP: begin
        if (!has_two) begin
          udf_d = 1'b1;
        end else begin
          mem_d[idx_next] = data_in;
          count_d         = cnt_m1;
        end
      end
      OP_CLEAR: count_d = '0;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // NOTE: the array has no reset; count=0 already marks every entry invalid,
  // so clearing it would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (!rst) mem_q <= mem_d;
  end

endmodule

// File: tb/tb_stack_unit.sv
// Directed self-checking bench for stack_unit (WIDTH=8, DEPTH=4) using
// immediate assertions against hand-computed expected values.
module tb_stack_unit;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  localparam logic [2:0] NOP = 3'b000, PUSH = 3'b001, POP = 3'b010, REPL = 3'b011,
                         DUP = 3'b100, SWAP = 3'b101, BINOP = 3'b110, CLEAR = 3'b111;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       op;
  logic [WIDTH-1:0] data_in;
  logic             err_clr;
  logic [WIDTH-1:0] tos, nos;
  logic [CW-1:0]    count;
  logic             empty, full, overflow, underflow;

  int checks = 0;
  int errors = 0;

  stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .op        (op),
    .data_in   (data_in),
    .err_clr   (err_clr),
    .tos       (tos),
    .nos       (nos),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one op across one rising edge, then settle 1 time unit past it.
  task automatic step(input logic [2:0] o, input logic [7:0] d, input logic clr, input logic r);
    op      = o;
    data_in = d;
    err_clr = clr;
    rst     = r;
    @(posedge clk);
    #1;
    op      = NOP;
    data_in = '0;
    err_clr = 1'b0;
    rst     = 1'b0;
  endtask

  task automatic check_state(input string tag, input int c, input logic [7:0] t,
                             input logic [7:0] n, input logic ov, input logic un);
    check({tag, ".count"}, 32'(count), 32'(c));
    check({tag, ".tos"}, 32'(tos), 32'(t));
    check({tag, ".nos"}, 32'(nos), 32'(n));
    check({tag, ".ovf"}, 32'(overflow), 32'(ov));
    check({tag, ".udf"}, 32'(underflow), 32'(un));
  endtask

  initial begin
    op = NOP; data_in = '0; err_clr = 1'b0; rst = 1'b1;

    // Reset with a PUSH presented: the op is discarded.
    step(PUSH, 8'hEE, 1'b0, 1'b1);
    check_state("reset", 0, 8'h00, 8'h00, 1'b0, 1'b0);
    check("reset.empty", 32'(empty), 32'd1);
    check("reset.full", 32'(full), 32'd0);

    // Basic push/pop.
    step(PUSH, 8'h11, 1'b0, 1'b0);
    check_state("push1", 1, 8'h11, 8'h00, 1'b0, 1'b0);
    check("push1.empty", 32'(empty), 32'd0);
    step(PUSH, 8'h22, 1'b0, 1'b0);
    step(PUSH, 8'h33, 1'b0, 1'b0);
    check_state("push3", 3, 8'h33, 8'h22, 1'b0, 1'b0);
    step(POP, 8'h00, 1'b0, 1'b0);
    check_state("pop", 2, 8'h22, 8'h11, 1'b0, 1'b0);

    // Fill to DEPTH, then overflow on PUSH and DUP.
    step(PUSH, 8'h44, 1'b0, 1'b0);
    step(PUSH, 8'h55, 1'b0, 1'b0);
    check_state("fill", 4, 8'h55, 8'h44, 1'b0, 1'b0);
    check("fill.full", 32'(full), 32'd1);
    step(PUSH, 8'hAA, 1'b0, 1'b0);
    check_state("push_full", 4, 8'h55, 8'h44, 1'b1, 1'b0);
    check("push_full.full", 32'(full), 32'd1);
    step(DUP, 8'h00, 1'b0, 1'b0);
    check_state("dup_full", 4, 8'h55, 8'h44, 1'b1, 1'b0);
    step(NOP, 8'h00, 1'b1, 1'b0);
    check_state("clr_ovf", 4, 8'h55, 8'h44, 1'b0, 1'b0);

    // err_clr coinciding with a new error: set wins. err_clr alone clears.
    step(PUSH, 8'hBB, 1'b1, 1'b0);
    check_state("clr_vs_set", 4, 8'h55, 8'h44, 1'b1, 1'b0);
    step(NOP, 8'h00, 1'b1, 1'b0);
    check("clr_only.ovf", 32'(overflow), 32'd0);

    // Set overflow again, pop to count=3, then reset with a PUSH pending.
    step(PUSH, 8'hCC, 1'b0, 1'b0);
    step(POP, 8'h00, 1'b0, 1'b0);
    check_state("pre_rst", 3, 8'h44, 8'h22, 1'b1, 1'b0);
    step(PUSH, 8'h77, 1'b0, 1'b1);
    check_state("mid_rst", 0, 8'h00, 8'h00, 1'b0, 1'b0);
    check("mid_rst.empty", 32'(empty), 32'd1);

    // Underflow cases from empty.
    step(POP, 8'h00, 1'b0, 1'b0);
    check_state("pop_empty", 0, 8'h00, 8'h00, 1'b0, 1'b1);
    step(SWAP, 8'h00, 1'b0, 1'b0);
    check_state("swap_empty", 0, 8'h00, 8'h00, 1'b0, 1'b1);
    step(PUSH, 8'h05, 1'b0, 1'b0);
    step(BINOP, 8'hFF, 1'b0, 1'b0);
    check_state("binop_one", 1, 8'h05, 8'h00, 1'b0, 1'b1);
    step(SWAP, 8'h00, 1'b0, 1'b0);
    check_state("swap_one", 1, 8'h05, 8'h00, 1'b0, 1'b1);
    step(CLEAR, 8'h00, 1'b1, 1'b0);
    check_state("clear_clr", 0, 8'h00, 8'h00, 1'b0, 1'b0);
    step(DUP, 8'h00, 1'b0, 1'b0);
    check_state("dup_empty", 0, 8'h00, 8'h00, 1'b0, 1'b1);
    step(NOP, 8'h00, 1'b1, 1'b0);
    step(REPL, 8'h66, 1'b0, 1'b0);
    check_state("repl_empty", 0, 8'h00, 8'h00, 1'b0, 1'b1);
    step(NOP, 8'h00, 1'b1, 1'b0);
    check("clr_udf", 32'(underflow), 32'd0);

    // ALU-style BINOP with data_in derived from the live tos/nos.
    step(PUSH, 8'h03, 1'b0, 1'b0);
    step(PUSH, 8'h04, 1'b0, 1'b0);
    check_state("pre_binop", 2, 8'h04, 8'h03, 1'b0, 1'b0);
    step(BINOP, tos + nos, 1'b0, 1'b0);
    check_state("binop", 1, 8'h07, 8'h00, 1'b0, 1'b0);
    step(DUP, 8'h00, 1'b0, 1'b0);
    check_state("dup", 2, 8'h07, 8'h07, 1'b0, 1'b0);
    step(SWAP, 8'h00, 1'b0, 1'b0);
    step(REPL, 8'h09, 1'b0, 1'b0);
    check_state("repl", 2, 8'h09, 8'h07, 1'b0, 1'b0);
    step(SWAP, 8'h00, 1'b0, 1'b0);
    check_state("swap", 2, 8'h07, 8'h09, 1'b0, 1'b0);

    // Fill and CLEAR: never an error.
    step(PUSH, 8'h0A, 1'b0, 1'b0);
    step(PUSH, 8'h0B, 1'b0, 1'b0);
    check_state("refill", 4, 8'h0B, 8'h0A, 1'b0, 1'b0);
    step(CLEAR, 8'h00, 1'b0, 1'b0);
    check_state("clear_full", 0, 8'h00, 8'h00, 1'b0, 1'b0);
    check("clear_full.empty", 32'(empty), 32'd1);
    check("clear_full.full", 32'(full), 32'd0);

    // Pop leaves data in place: a PUSH after CLEAR overwrites entry 0 only.
    step(PUSH, 8'h21, 1'b0, 1'b0);
    step(PUSH, 8'h42, 1'b0, 1'b0);
    step(POP, 8'h00, 1'b0, 1'b0);
    check_state("pop_to_one", 1, 8'h21, 8'h00, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
